debug_run_controller: RTL and testbench

//  Command sequencer for the MIPS debug path. Decodes single-byte commands from the UART receiver.

---
 rtl/debug_run_controller.sv | 152 +++++++++++++++
 tb/tb_debug_run_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_run_controller.sv
// debug_run_controller
//   Command sequencer for the MIPS debug path. Decodes single-byte UART commands and drives the
//   pipeline enable for continuous-run ('C') or single-step ('S') execution. It triggers a
//   register/memory dump after execution or on request ('R'), and clears the pipeline, counter and
//   sticky flags on 'X'. It also keeps the count of enabled pipeline cycles, which the dump sends.
//
//   Optional feature: define DBG_WATCHDOG_EN to bound each 'C' run to MAX_RUN cycles. When the
//   bound is hit, O_TIMEOUT is set and a dump is forced. Without the macro, O_TIMEOUT is tied to 0.
//
// Ports
//   CLK            in   1   system clock, rising edge
//   RESET_N        in   1   asynchronous active-low reset
//   I_RX_DONE      in   1   strobe: I_RX_DATA holds a received byte
//   I_RX_DATA      in   8   received command byte
//   I_HALT         in   1   level: program end reached
//   I_DUMP_DONE    in   1   strobe: dump unit finished
//   O_PIPE_EN      out  1   pipeline clock-enable
//   O_PIPE_RESET   out  1   one-cycle pipeline reset request
//   O_READ_REGS    out  1   one-cycle dump trigger
//   O_ITERACIONES  out  32  enabled cycles since reset / 'X'
//   O_HALTED       out  1   sticky halt flag
//   O_TIMEOUT      out  1   sticky watchdog flag
//   O_BUSY         out  1   controller not idle

module debug_run_controller #(
  parameter logic [7:0]  CMD_CONT  = 8'h43,
  parameter logic [7:0]  CMD_STEP  = 8'h53,
  parameter logic [7:0]  CMD_READ  = 8'h52,
  parameter logic [7:0]  CMD_CLEAR = 8'h58,
  parameter logic [31:0] MAX_RUN   = 32'd1_000_000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        I_RX_DONE,
  input  logic [7:0]  I_RX_DATA,
  input  logic        I_HALT,
  input  logic        I_DUMP_DONE,
  output logic        O_PIPE_EN,
  output logic        O_PIPE_RESET,
  output logic        O_READ_REGS,
  output logic [31:0] O_ITERACIONES,
  output logic        O_HALTED,
  output logic        O_TIMEOUT,
  output logic        O_BUSY
);

  typedef enum logic [5:0] {
    StIdle     = 6'b000001,
    StRun      = 6'b000010,
    StStep     = 6'b000100,
    StDumpReq  = 6'b001000,
    StDumpWait = 6'b010000,
    StClear    = 6'b100000
  } state_e;

  state_e      state_q;
  logic [31:0] iter_q;
  logic        halted_q;
  logic        wd_hit;

`ifdef DBG_WATCHDOG_EN
  logic [31:0] run_cnt_q;
  logic        timeout_q;

  // Halt wins over the watchdog when both land on the same cycle.
  assign wd_hit    = (state_q == StRun) && (run_cnt_q == MAX_RUN) && !I_HALT;
  assign O_TIMEOUT = timeout_q;
`else
  assign wd_hit    = 1'b0;
  assign O_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      iter_q    <= 32'd0;
      halted_q  <= 1'b0;
`ifdef DBG_WATCHDOG_EN
      run_cnt_q <= 32'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // Wraps silently at 32 bits.
      if (O_PIPE_EN) iter_q <= iter_q + 32'd1;

      unique case (state_q)
        StIdle: begin
          if (I_RX_DONE) begin
            if (I_RX_DATA == CMD_CONT) begin
              state_q <= halted_q ? StDumpReq : StRun;
`ifdef DBG_WATCHDOG_EN
              run_cnt_q <= 32'd0;
`endif
            end else if (I_RX_DATA == CMD_STEP) begin
              state_q <= halted_q ? StDumpReq : StStep;
            end else if (I_RX_DATA == CMD_READ) begin
              state_q <= StDumpReq;
            end else if (I_RX_DATA == CMD_CLEAR) begin
              state_q <= StClear;
            end
          end
        end
        StRun: begin
          if (I_HALT) begin
            halted_q <= 1'b1;
            state_q  <= StDumpReq;
          end else if (wd_hit) begin
`ifdef DBG_WATCHDOG_EN
            timeout_q <= 1'b1;
`endif
            state_q <= StDumpReq;
          end else begin
`ifdef DBG_WATCHDOG_EN
            run_cnt_q <= run_cnt_q + 32'd1;
`endif
          end
        end
        StStep: begin
          if (I_HALT) halted_q <= 1'b1;
          state_q <= StDumpReq;
        end
        StDumpReq: begin
          state_q <= StDumpWait;
        end
        StDumpWait: begin
          // Any byte arriving alongside I_DUMP_DONE is dropped: it is only looked at in IDLE.
          if (I_DUMP_DONE) state_q <= StIdle;
        end
        StClear: begin
          iter_q   <= 32'd0;
          halted_q <= 1'b0;
`ifdef DBG_WATCHDOG_EN
          timeout_q <= 1'b0;
`endif
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Pipeline enable stays combinational, so the halt cycle itself never advances the pipeline.
  assign O_PIPE_EN     = ((state_q == StRun) || (state_q == StStep)) && !I_HALT && !wd_hit;
  assign O_READ_REGS   = (state_q == StDumpReq);
  assign O_PIPE_RESET  = (state_q == StClear);
  assign O_BUSY        = (state_q != StIdle);
  assign O_ITERACIONES = iter_q;
  assign O_HALTED      = halted_q;

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed self-checking bench for debug_run_controller.

module tb_debug_run_controller;

`ifdef DBG_WATCHDOG_EN
  localparam logic [31:0] TbMaxRun = 32'd5;
`else
  localparam logic [31:0] TbMaxRun = 32'd1_000_000;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        I_RX_DONE = 1'b0;
  logic [7:0]  I_RX_DATA = 8'h00;
  logic        I_HALT = 1'b0;
  logic        I_DUMP_DONE = 1'b0;
  logic        O_PIPE_EN;
  logic        O_PIPE_RESET;
  logic        O_READ_REGS;
  logic [31:0] O_ITERACIONES;
  logic        O_HALTED;
  logic        O_TIMEOUT;
  logic        O_BUSY;

  int checks = 0;
  int errors = 0;
  int en_cnt;

  debug_run_controller #(
    .MAX_RUN (TbMaxRun)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .I_RX_DONE     (I_RX_DONE),
    .I_RX_DATA     (I_RX_DATA),
    .I_HALT        (I_HALT),
    .I_DUMP_DONE   (I_DUMP_DONE),
    .O_PIPE_EN     (O_PIPE_EN),
    .O_PIPE_RESET  (O_PIPE_RESET),
    .O_READ_REGS   (O_READ_REGS),
    .O_ITERACIONES (O_ITERACIONES),
    .O_HALTED      (O_HALTED),
    .O_TIMEOUT     (O_TIMEOUT),
    .O_BUSY        (O_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    I_RX_DATA = b;
    I_RX_DONE = 1'b1;
    tick();
    I_RX_DONE = 1'b0;
  endtask

  task automatic dump_done();
    I_DUMP_DONE = 1'b1;
    tick();
    I_DUMP_DONE = 1'b0;
  endtask

  // Packs the control outputs {busy, pipe_en, read_regs, pipe_reset, halted, timeout}.
  function automatic logic [31:0] ctl();
    return {26'd0, O_BUSY, O_PIPE_EN, O_READ_REGS, O_PIPE_RESET, O_HALTED, O_TIMEOUT};
  endfunction

  initial begin
    // Reset
    #3 RESET_N = 1'b0;
    #1;
    check("reset_ctl", ctl(), 32'h0);
    check("reset_iter", O_ITERACIONES, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    check("idle_after_reset", ctl(), 32'h0);

    // Test 1: single step
    send(8'h53);
    check("step_ctl", ctl(), 32'b110000);
    check("step_iter_before", O_ITERACIONES, 32'd0);
    tick();
    check("step_dumpreq_ctl", ctl(), 32'b101000);
    check("step_iter", O_ITERACIONES, 32'd1);
    tick();
    check("step_dumpwait_ctl", ctl(), 32'b100000);
    dump_done();
    check("step_back_idle", ctl(), 32'h0);

    // Test 4a: unknown byte ignored in IDLE
    send(8'h51);
    check("q_ignored_ctl", ctl(), 32'h0);
    check("q_ignored_iter", O_ITERACIONES, 32'd1);
    tick();
    check("q_ignored_ctl2", ctl(), 32'h0);

    // Clear before the run test so the count starts at zero
    send(8'h58);
    check("clear1_ctl", ctl(), 32'b100100);
    tick();
    check("clear1_iter", O_ITERACIONES, 32'd0);
    check("clear1_idle", ctl(), 32'h0);

    // Test 2: continuous run, halt after 10 enabled cycles
    send(8'h43);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (O_PIPE_EN) en_cnt++;
      tick();
    end
    check("run_still_busy", O_BUSY, 1'b1);
    I_HALT = 1'b1;
    #1;
    check("run_halt_no_en", O_PIPE_EN, 1'b0);
    tick();
    check("run_en_cycles", en_cnt, 32'd10);
    check("run_iter", O_ITERACIONES, 32'd10);
    check("run_dumpreq_ctl", ctl(), 32'b101010);
    tick();
    check("run_dumpwait_ctl", ctl(), 32'b100010);

    // Test 4b: byte during DUMP_WAIT dropped
    send(8'h53);
    check("drop_in_wait_ctl", ctl(), 32'b100010);
    tick();
    tick();
    check("wait_hold_ctl", ctl(), 32'b100010);
    check("wait_hold_iter", O_ITERACIONES, 32'd10);
    // Byte alongside I_DUMP_DONE is dropped
    I_RX_DATA = 8'h52;
    I_RX_DONE = 1'b1;
    dump_done();
    I_RX_DONE = 1'b0;
    check("done_to_idle", ctl(), 32'b000010);
    tick();
    check("same_cycle_byte_dropped", ctl(), 32'b000010);

    // Test 3: halted, 'S' and 'C' only dump
    send(8'h53);
    check("halted_step_ctl", ctl(), 32'b101010);
    tick();
    dump_done();
    check("halted_step_idle", ctl(), 32'b000010);
    send(8'h43);
    check("halted_cont_ctl", ctl(), 32'b101010);
    tick();
    dump_done();
    check("halted_iter", O_ITERACIONES, 32'd10);

    // 'R' dumps without executing
    I_HALT = 1'b0;
    send(8'h52);
    check("read_ctl", ctl(), 32'b101010);
    tick();
    dump_done();

    // Test 5: clear
    send(8'h58);
    check("clear2_ctl", ctl(), 32'b100110);
    tick();
    check("clear2_ctl_after", ctl(), 32'h0);
    check("clear2_iter", O_ITERACIONES, 32'd0);

    // Test 6: asynchronous reset mid-run
    send(8'h43);
    tick();
    tick();
    check("run2_iter", O_ITERACIONES, 32'd2);
    #2 RESET_N = 1'b0;
    #1;
    check("async_reset_ctl", ctl(), 32'h0);
    check("async_reset_iter", O_ITERACIONES, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    check("post_reset_idle", ctl(), 32'h0);

`ifdef DBG_WATCHDOG_EN
    // Watchdog with MAX_RUN = 5
    send(8'h43);
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (O_PIPE_EN) en_cnt++;
      tick();
    end
    check("wd_en_cycles", en_cnt, 32'd5);
    check("wd_hit_no_en", O_PIPE_EN, 1'b0);
    tick();
    check("wd_dumpreq_ctl", ctl(), 32'b101001);
    check("wd_iter", O_ITERACIONES, 32'd5);
    tick();
    dump_done();
    send(8'h58);
    tick();
    check("wd_cleared", ctl(), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
